// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO controller for a sync-write / async-read dual-port RAM.
// The controller owns the write and read pointers, the occupancy count, the
// full/empty flags and the sticky overflow/underflow flags. The RAM itself
// lives outside this block. Its read port is combinational, so the head entry
// is presented on dout with no extra register (first-word-fall-through).
//
// Optional build feature:
//    SYNC_FIFO_WMARK_EN  when defined, adds almost_full / almost_empty
//                        watermark outputs decoded from the registered count.
//
// Ports
//    clk           in   1          single clock (RAM write/read clocks tie here)
//    rst           in   1          synchronous reset, active-high
//    flush         in   1          synchronous clear of pointers, count, errors
//    wr_req        in   1          push request
//    wr_din        in   DWIDTH     push data
//    full          out  1          count == 2**AWIDTH
//    rd_req        in   1          pop request, acknowledges current dout
//    dout          out  DWIDTH     head entry (valid while empty == 0)
//    empty         out  1          count == 0
//    count         out  AWIDTH+1   occupancy 0 .. 2**AWIDTH
//    overflow      out  1          sticky: push attempted while full
//    underflow     out  1          sticky: pop attempted while empty
//    ram_wr_en     out  1          RAM write enable
//    ram_wr_addr   out  AWIDTH     RAM write address
//    ram_wr_data   out  DWIDTH     RAM write data
//    ram_rd_addr   out  AWIDTH     RAM read address
//    ram_rd_data   in   DWIDTH     RAM read data (combinational)
//    almost_full   out  1          count >= AF_LEVEL (SYNC_FIFO_WMARK_EN only)
//    almost_empty  out  1          count <= AE_LEVEL (SYNC_FIFO_WMARK_EN only)
//
// The controller has no sequencing FSM; its state is two pointers, a count
// and two sticky flags.
// ---------------------------------------------------------------------------
module sync_fifo_ctrl #(
   parameter int DWIDTH   = 8,
   parameter int AWIDTH   = 6,
   parameter int AF_LEVEL = 48,
   parameter int AE_LEVEL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_req,
   input  logic [DWIDTH-1:0] wr_din,
   output logic              full,
   input  logic              rd_req,
   output logic [DWIDTH-1:0] dout,
   output logic              empty,
   output logic [AWIDTH:0]   count,
   output logic              overflow,
   output logic              underflow,
   output logic              ram_wr_en,
   output logic [AWIDTH-1:0] ram_wr_addr,
   output logic [DWIDTH-1:0] ram_wr_data,
   output logic [AWIDTH-1:0] ram_rd_addr,
   input  logic [DWIDTH-1:0] ram_rd_data
`ifdef SYNC_FIFO_WMARK_EN
   ,
   output logic              almost_full,
   output logic              almost_empty
`endif
);

   localparam int              DEPTH    = 1 << AWIDTH;
   localparam logic [AWIDTH:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH:0] CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
   localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

   // Watermark levels beyond the depth would make a flag unreachable or
   // stuck; catch that at elaboration rather than in the field.
   if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH)
   begin : g_level_check
      $error("sync_fifo_ctrl: watermark level outside 0..2**AWIDTH");
   end

   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic              wr_acc;
   logic              rd_acc;
   logic              wr_rej;
   logic              rd_rej;

   // Flags decode the current registered count; a same-cycle pop does not
   // make room for a same-cycle push at full, and vice versa at empty.
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   assign wr_acc = wr_req & ~full  & ~flush;
   assign rd_acc = rd_req & ~empty & ~flush;
   assign wr_rej = wr_req &  full  & ~flush;
   assign rd_rej = rd_req &  empty & ~flush;

   assign ram_wr_en   = wr_acc;
   assign ram_wr_addr = wr_ptr;
   assign ram_wr_data = wr_din;
   assign ram_rd_addr = rd_ptr;
   assign dout        = ram_rd_data;

   // Pointers wrap naturally at 2**AWIDTH; full/empty never look at them.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (wr_rej) begin
            overflow <= 1'b1;
         end
         if (rd_rej) begin
            underflow <= 1'b1;
         end
      end
   end

`ifdef SYNC_FIFO_WMARK_EN
   localparam logic [AWIDTH:0] AF_CNT = AF_LEVEL[AWIDTH:0];
   localparam logic [AWIDTH:0] AE_CNT = AE_LEVEL[AWIDTH:0];

   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);
`endif

endmodule
